pc_sequencer: RTL

//  Instruction fetch/issue controller between the program ROM and the execute unit. Owns the PC,

---
 rtl/pc_sequencer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction fetch/issue controller between program ROM and execute unit.
// Owns the PC, latches ROM words into IR, resolves JMP/JOV internally, issues all other
// opcodes over IR_VALID/EXEC_READY, and treats a jump to its own address as HALT.
// Optional breakpoint support is compiled in when the macro PCSEQ_BREAK_EN is defined.
module pc_sequencer #(
    parameter int unsigned ROM_WIDTH = 21,
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [4:0]  OP_JMP    = 5'b01001,
    parameter logic [4:0]  OP_JOV    = 5'b01011
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 RUN,
    output logic [15:0]          ROM_ADDR,
    input  logic [ROM_WIDTH-1:0] ROM_DATA,
    output logic [ROM_WIDTH-1:0] IR,
    output logic                 IR_VALID,
    input  logic                 EXEC_READY,
    input  logic                 EXEC_BUSY,
    input  logic                 OV,
    output logic [15:0]          PC,
    output logic                 HALTED,
    output logic [15:0]          RETIRED
`ifdef PCSEQ_BREAK_EN
    ,
    input  logic [15:0]          BP_ADDR,
    input  logic                 BP_ENA,
    output logic                 BP_HIT,
    input  logic                 RESUME
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DECODE   = 3'd2,
        ST_ISSUE    = 3'd3,
        ST_WAITFLAG = 3'd4,
        ST_HALT     = 3'd5
`ifdef PCSEQ_BREAK_EN
        ,
        ST_BREAK    = 3'd6
`endif
    } state_t;

    state_t                 state_q, state_d;
    logic [15:0]            pc_q, pc_d;
    logic [ROM_WIDTH-1:0]   ir_q, ir_d;
    logic                   ir_valid_q, ir_valid_d;
    logic                   halted_q, halted_d;
    logic [15:0]            retired_q, retired_d;

    logic [4:0]             opcode;
    logic [15:0]            operand;
    logic [15:0]            pc_inc;
    logic [15:0]            retired_inc;
    state_t                 after_state;

`ifdef PCSEQ_BREAK_EN
    logic                   bp_hit_q, bp_hit_d;
    logic                   bp_skip_q, bp_skip_d;
`endif

    assign opcode      = ir_q[ROM_WIDTH-1 -: 5];
    assign operand     = ir_q[15:0];
    assign pc_inc      = pc_q + 16'd1;
    assign retired_inc = (retired_q == 16'hFFFF) ? retired_q : retired_q + 16'd1;
    // Where to go once the current instruction has completed.
    assign after_state = RUN ? ST_FETCH : ST_IDLE;

    assign ROM_ADDR = pc_q;
    assign PC       = pc_q;
    assign IR       = ir_q;
    assign IR_VALID = ir_valid_q;
    assign HALTED   = halted_q;
    assign RETIRED  = retired_q;
`ifdef PCSEQ_BREAK_EN
    assign BP_HIT   = bp_hit_q;
`endif

    // Next-state and datapath updates for the fetch/decode/issue sequence.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        halted_d   = halted_q;
        retired_d  = retired_q;
`ifdef PCSEQ_BREAK_EN
        bp_hit_d   = bp_hit_q;
        bp_skip_d  = bp_skip_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (RUN) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
`ifdef PCSEQ_BREAK_EN
                // A breakpoint suppresses the fetch unless we are resuming from it.
                if (BP_ENA && (pc_q == BP_ADDR) && !bp_skip_q) begin
                    bp_hit_d = 1'b1;
                    state_d  = ST_BREAK;
                end else begin
                    bp_skip_d = 1'b0;
                    ir_d      = ROM_DATA;
                    state_d   = ST_DECODE;
                end
`else
                ir_d    = ROM_DATA;
                state_d = ST_DECODE;
`endif
            end
            ST_DECODE: begin
                if (opcode == OP_JMP) begin
                    retired_d = retired_inc;
                    if (operand == pc_q) begin
                        halted_d = 1'b1;
                        state_d  = ST_HALT;
                    end else begin
                        pc_d    = operand;
                        state_d = after_state;
                    end
                end else if (opcode == OP_JOV) begin
                    state_d = ST_WAITFLAG;
                end else begin
                    ir_valid_d = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end
            ST_WAITFLAG: begin
                // OV is only meaningful once the execute unit has drained.
                if (!EXEC_BUSY) begin
                    retired_d = retired_inc;
                    if (OV && (operand == pc_q)) begin
                        halted_d = 1'b1;
                        state_d  = ST_HALT;
                    end else if (OV) begin
                        pc_d    = operand;
                        state_d = after_state;
                    end else begin
                        pc_d    = pc_inc;
                        state_d = after_state;
                    end
                end
            end
            ST_ISSUE: begin
                if (EXEC_READY) begin
                    ir_valid_d = 1'b0;
                    pc_d       = pc_inc;
                    retired_d  = retired_inc;
                    state_d    = after_state;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
`ifdef PCSEQ_BREAK_EN
            ST_BREAK: begin
                if (RESUME) begin
                    bp_hit_d  = 1'b0;
                    bp_skip_d = 1'b1;
                    state_d   = ST_FETCH;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset discards any in-flight instruction immediately.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
            retired_q  <= 16'd0;
`ifdef PCSEQ_BREAK_EN
            bp_hit_q   <= 1'b0;
            bp_skip_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            halted_q   <= halted_d;
            retired_q  <= retired_d;
`ifdef PCSEQ_BREAK_EN
            bp_hit_q   <= bp_hit_d;
            bp_skip_q  <= bp_skip_d;
`endif
        end
    end

endmodule
